lcd_ctrl: RTL

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 write-only panel controller: power-up wait, fixed init command list,
// then one accepted word at a time with setup / EN pulse / hold / busy-wait timing.
module lcd_ctrl #(
    parameter int unsigned P_PWRUP    = 750000,
    parameter int unsigned P_SETUP    = 2,
    parameter int unsigned P_EN_HIGH  = 12,
    parameter int unsigned P_HOLD     = 2,
    parameter int unsigned P_WAIT_CMD = 2000,
    parameter int unsigned P_WAIT_CLR = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_lcd_word,
    output logic        o_ready,
    output logic        o_init_done,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon
);

    localparam int unsigned CNT_W = 24;

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_SETUP = 3'd3;
    localparam logic [2:0] S_EN_HI = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;
    logic             blon_q, blon_d;
    logic             on_q, on_d;

    logic [CNT_W-1:0] limit_c;
    logic             done_c;
    logic             accept_c;
    logic             is_clr_c;
    logic [7:0]       cmd_c;
    logic             unused_bits;

    assign unused_bits = ^{i_lcd_word[31], i_lcd_word[29:9]};
    assign accept_c    = i_valid && ready_q;
    assign is_clr_c    = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    // Init command list, indexed by the number of commands already issued
    always_comb begin
        cmd_c = 8'h38;
        case (idx_q)
            2'd0:    cmd_c = 8'h38;
            2'd1:    cmd_c = 8'h0C;
            2'd2:    cmd_c = 8'h01;
            default: cmd_c = 8'h06;
        endcase
    end

    // Length of the current state in cycles; the counter counts up from 0 at entry
    always_comb begin
        limit_c = CNT_W'(1);
        case (state_q)
            S_PWRUP: limit_c = CNT_W'(P_PWRUP);
            S_SETUP: limit_c = CNT_W'(P_SETUP);
            S_EN_HI: limit_c = CNT_W'(P_EN_HIGH);
            S_HOLD:  limit_c = CNT_W'(P_HOLD);
            S_WAIT:  limit_c = is_clr_c ? CNT_W'(P_WAIT_CLR) : CNT_W'(P_WAIT_CMD);
            default: limit_c = CNT_W'(1);
        endcase
    end

    assign done_c = (cnt_q >= (limit_c - CNT_W'(1)));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        rs_d        = rs_q;
        init_done_d = init_done_q;
        blon_d      = blon_q;
        on_d        = 1'b1;
        case (state_q)
            S_PWRUP: if (done_c) state_d = S_INIT;
            S_INIT: begin
                state_d = S_SETUP;
                data_d  = cmd_c;
                rs_d    = 1'b0;
            end
            S_IDLE: if (accept_c) begin
                state_d = S_SETUP;
                data_d  = i_lcd_word[7:0];
                rs_d    = i_lcd_word[8];
                blon_d  = i_lcd_word[30];
            end
            S_SETUP: if (done_c) state_d = S_EN_HI;
            S_EN_HI: if (done_c) state_d = S_HOLD;
            S_HOLD:  if (done_c) state_d = S_WAIT;
            S_WAIT: if (done_c) begin
                if (init_done_q) begin
                    state_d = S_IDLE;
                end else if (idx_q == 2'd3) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    state_d = S_INIT;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = S_PWRUP;
        endcase
        // Restart at every state change; parked at zero in IDLE so it never wraps
        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
        else                                         cnt_d = cnt_q + CNT_W'(1);
        en_d    = (state_d == S_EN_HI);
        ready_d = (state_d == S_IDLE) && init_done_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            blon_q      <= 1'b0;
            on_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            blon_q      <= blon_d;
            on_q        <= on_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_init_done = init_done_q;
    assign o_lcd_data  = data_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_blon  = blon_q;

endmodule
